op_frame_parser: RTL and testbench
==================================

Name: op_frame_parser

Overview:
- Upstream stage of the 32-bit subtract/ALU block.
- Receives a byte stream over a valid/ready handshake and assembles one operation frame: a header byte, then operand A (4 bytes), then operand B (4 bytes).
- Drives a, b, operator, data_type and a one-cycle parser_done strobe directly into the ALU.
- Holds off the next frame until the ALU returns alu_done; flags malformed or stalled frames.

Parameters:
- HDR_MAGIC, 6'h2A, required value of header bits [7:2].
- TIMEOUT_CYCLES, 255, max idle cycles between bytes inside a frame before abort; 0 disables the timeout.
- TO_W, 8, width of the idle counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous, active-high reset (1 = reset asserted).
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  parser accepts in_data this cycle.
- alu_done  in  1  ALU completion, from the downstream stage.
- a  out  32  operand A to ALU.
- b  out  32  operand B to ALU.
- operator  out  1  operation select (header bit 0).
- data_type  out  1  data type select (header bit 1).
- parser_done  out  1  one-cycle strobe: a/b/operator/data_type are valid.
- frame_err  out  1  one-cycle strobe on a bad header or a timeout abort.

Behaviour:
- Reset (async, while n_rst=1): a=0, b=0, operator=0, data_type=0, parser_done=0, frame_err=0, in_ready=0. FSM goes to HDR; byte count, idle count and shadow registers clear. Reset mid-frame discards the partial frame.
- Byte accept: in_valid & in_ready at a rising edge. in_ready is decoded from state: 1 in HDR/OPA/OPB, 0 in DONE/WAIT and during reset.
- FSM states: HDR, OPA, OPB, DONE, WAIT.
- HDR:
  - Accepted byte with [7:2]==HDR_MAGIC: latch bit0 into shadow op and bit1 into shadow dt, clear cnt, go to OPA.
  - Any other byte: frame_err=1 for one cycle, stay in HDR, outputs unchanged.
- OPA: shift each accepted byte into shadow A, MSB first (first byte lands in [31:24]). On the 4th byte (cnt==3), clear cnt and go to OPB.
- OPB: same as OPA into shadow B. On the 4th byte, go to DONE. At that same edge, copy shadow A/B/op/dt to a/b/operator/data_type and register parser_done=1.
- DONE (one cycle, parser_done=1):
  - alu_done=1 in this cycle (ALU may tie it combinationally to parser_done): go to HDR.
  - Otherwise: go to WAIT.
- WAIT: parser_done=0; stay until alu_done=1, then go to HDR. No timeout in WAIT.
- Output stability: a/b/operator/data_type change only on the parser_done-setting edge and hold until the next frame completes. Errors and timeouts never alter them.
- Latency: with in_valid held high, the header plus 8 bytes are accepted on 9 consecutive edges. parser_done is high in the cycle after the 9th accept. The earliest next header accept is the cycle after DONE.
- Timeout (TIMEOUT_CYCLES>0, states OPA/OPB only):
  - idle counter increments each cycle with no accept and clears on every accept and on entry to OPA.
  - When idle==TIMEOUT_CYCLES: frame_err=1 for one cycle, discard the shadow registers, go to HDR.
  - Same-edge accept and timeout threshold: the accept wins and the counter clears.
- parser_done and frame_err are never high in the same cycle.
- No arithmetic beyond counter increments. cnt is 2 bits and wraps only under FSM control. The idle counter saturates at TIMEOUT_CYCLES.

Test Plan:
- Basic frame: bytes A9,00,00,00,05,00,00,00,03 back-to-back, alu_done tied to parser_done -> parser_done pulses once, 1 cycle after the last accept; a=0x00000005, b=0x00000003, operator=1, data_type=0; in_ready low for exactly 1 cycle.
- Field/byte order: header AA, A=DE,AD,BE,EF, B=01,23,45,67 with random in_valid gaps under 255 -> a=0xDEADBEEF, b=0x01234567, operator=0, data_type=1.
- Bad header: byte 0x55, then a valid frame -> frame_err 1-cycle pulse, outputs unchanged, next frame decoded correctly.
- Backpressure: alu_done held 0 for 20 cycles after parser_done -> in_ready=0 throughout WAIT; the next header is accepted only after the alu_done pulse.
- Timeout: header plus 2 bytes of A, then in_valid=0 for 255 cycles -> frame_err pulses on the 255th idle cycle, a/b keep their previous values, a fresh frame parses normally.
- Reset mid-frame: n_rst=1 after 5 bytes -> all outputs 0 immediately (async); after release, a full frame yields the correct a/b.

Source files
------------

// File: rtl/op_frame_parser.sv
// Byte-stream front end for the 32-bit ALU: assembles header + operand A + operand B
// into one operation, strobes parser_done, and holds off the next frame until alu_done.
module op_frame_parser #(
  parameter logic [5:0] HDR_MAGIC      = 6'h2A,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         TO_W           = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        alu_done,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic        operator,
  output logic        data_type,
  output logic        parser_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_OPA  = 3'd1,
    ST_OPB  = 3'd2,
    ST_DONE = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_r, state_s;
  logic [1:0]      cnt_r, cnt_s;
  logic [TO_W-1:0] idle_r, idle_s;
  logic [31:0]     sh_a_r, sh_a_s, sh_b_r, sh_b_s;
  logic            sh_op_r, sh_op_s, sh_dt_r, sh_dt_s;
  logic            ready_s, accept_s, timeout_s, load_s, err_s;

  assign ready_s   = (state_r == ST_HDR) || (state_r == ST_OPA) || (state_r == ST_OPB);
  assign in_ready  = ready_s & ~n_rst;
  assign accept_s  = in_valid & ready_s;
  // The abort fires on the edge that closes the TIMEOUT_CYCLES-th idle cycle; an accept on that edge wins.
  assign timeout_s = TO_EN && !accept_s && (idle_r == TO_LAST);

  // Next-state, shadow assembly and strobe decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idle_s  = idle_r;
    sh_a_s  = sh_a_r;
    sh_b_s  = sh_b_r;
    sh_op_s = sh_op_r;
    sh_dt_s = sh_dt_r;
    load_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_HDR: begin
        if (accept_s && (in_data[7:2] == HDR_MAGIC)) begin
          sh_op_s = in_data[0];
          sh_dt_s = in_data[1];
          cnt_s   = 2'd0;
          idle_s  = {TO_W{1'b0}};
          state_s = ST_OPA;
        end else if (accept_s) begin
          err_s = 1'b1;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_OPA, ST_OPB: begin
        if (accept_s) begin
          idle_s = {TO_W{1'b0}};
          if (state_r == ST_OPA) begin
            sh_a_s = {sh_a_r[23:0], in_data};
          end else begin
            sh_b_s = {sh_b_r[23:0], in_data};
          end
          if (cnt_r == 2'd3) begin
            cnt_s   = 2'd0;
            state_s = (state_r == ST_OPA) ? ST_OPB : ST_DONE;
            load_s  = (state_r == ST_OPB);
          end else begin
            cnt_s = cnt_r + 2'd1;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          sh_a_s  = 32'd0;
          sh_b_s  = 32'd0;
          sh_op_s = 1'b0;
          sh_dt_s = 1'b0;
          cnt_s   = 2'd0;
          idle_s  = {TO_W{1'b0}};
          state_s = ST_HDR;
        end else if (idle_r != TO_MAX) begin
          idle_s = idle_r + TO_W'(1);
        end else begin
          idle_s = idle_r;
        end
      end
      ST_DONE: begin
        if (alu_done) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (alu_done) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_HDR;
      end
    endcase
  end

  // State, shadow and registered ALU-facing outputs.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r     <= ST_HDR;
      cnt_r       <= 2'd0;
      idle_r      <= {TO_W{1'b0}};
      sh_a_r      <= 32'd0;
      sh_b_r      <= 32'd0;
      sh_op_r     <= 1'b0;
      sh_dt_r     <= 1'b0;
      a           <= 32'd0;
      b           <= 32'd0;
      operator    <= 1'b0;
      data_type   <= 1'b0;
      parser_done <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idle_r      <= idle_s;
      sh_a_r      <= sh_a_s;
      sh_b_r      <= sh_b_s;
      sh_op_r     <= sh_op_s;
      sh_dt_r     <= sh_dt_s;
      parser_done <= load_s;
      frame_err   <= err_s;
      if (load_s) begin
        a         <= sh_a_r;
        b         <= sh_b_s;
        operator  <= sh_op_r;
        data_type <= sh_dt_r;
      end else begin
        a         <= a;
        b         <= b;
        operator  <= operator;
        data_type <= data_type;
      end
    end
  end

endmodule

// File: tb/tb_op_frame_parser.sv
// Directed bench for op_frame_parser: a byte-array frame model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_op_frame_parser;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        alu_tie = 1'b1;
  logic        alu_drv = 1'b0;
  wire         in_ready, alu_done, operator, data_type, parser_done, frame_err;
  wire  [31:0] a, b;

  int errors = 0;
  int checks = 0;
  int pd_count = 0;

  assign alu_done = alu_tie ? parser_done : alu_drv;

  op_frame_parser #(.HDR_MAGIC(6'h2A), .TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .alu_done(alu_done), .a(a), .b(b), .operator(operator), .data_type(data_type),
    .parser_done(parser_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: collected frame bytes, busy phase, idle count.
  int          m_len, m_wait, m_idle;
  logic [7:0]  fb [0:7];
  logic        m_op_sh, m_dt_sh, m_op, m_dt, m_pd, m_err, m_acc, alu_m;
  logic [31:0] m_a, m_b;

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      m_len = 0; m_wait = 0; m_idle = 0;
      m_a = 32'd0; m_b = 32'd0; m_op = 1'b0; m_dt = 1'b0;
      m_pd = 1'b0; m_err = 1'b0; m_acc = 1'b0;
    end else begin
      alu_m = alu_tie ? m_pd : alu_drv;
      m_acc = in_valid && (m_wait == 0);
      m_pd = 1'b0;
      m_err = 1'b0;
      if (m_wait == 1) begin
        m_wait = alu_m ? 0 : 2;
      end else if (m_wait == 2) begin
        if (alu_m) m_wait = 0;
      end else if (m_acc) begin
        m_idle = 0;
        if (m_len == 0) begin
          if (in_data[7:2] == 6'h2A) begin
            m_op_sh = in_data[0]; m_dt_sh = in_data[1]; m_len = 1;
          end else begin
            m_err = 1'b1;
          end
        end else begin
          fb[m_len-1] = in_data;
          m_len++;
          if (m_len == 9) begin
            m_a = {fb[0], fb[1], fb[2], fb[3]};
            m_b = {fb[4], fb[5], fb[6], fb[7]};
            m_op = m_op_sh; m_dt = m_dt_sh;
            m_pd = 1'b1; m_wait = 1; m_len = 0;
          end
        end
      end else if (m_len > 0) begin
        m_idle++;
        if (m_idle == T) begin
          m_err = 1'b1; m_len = 0; m_idle = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, !n_rst && (m_wait == 0)});
    chk("parser_done", {31'd0, parser_done}, {31'd0, m_pd});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("operator", {31'd0, operator}, {31'd0, m_op});
    chk("data_type", {31'd0, data_type}, {31'd0, m_dt});
    if (parser_done) pd_count++;
  end

  task automatic send(input logic [7:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
    in_data = d; in_valid = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!m_acc && n < 200);
    if (!m_acc) begin
      checks++; errors++;
      $display("FAIL accept_wait: byte %0h not accepted in %0d cycles", d, n);
    end
  endtask

  task automatic frame(input logic [7:0] h, input logic [31:0] av, input logic [31:0] bv,
                       input int maxgap, input int first_gap);
    logic [7:0] d;
    int g;
    send(h, 0);
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? av[31-8*i -: 8] : bv[31-8*(i-4) -: 8];
      g = (i == 0) ? first_gap : ((maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      send(d, g);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_frame(input string nm, input logic [31:0] av, input logic [31:0] bv,
                           input logic op, input logic dt);
    chk({nm, "_done"}, {31'd0, parser_done}, 32'd1);
    chk({nm, "_a"}, a, av);
    chk({nm, "_b"}, b, bv);
    chk({nm, "_op"}, {31'd0, operator}, {31'd0, op});
    chk({nm, "_dt"}, {31'd0, data_type}, {31'd0, dt});
  endtask

  initial begin
    #1;
    chk("rst_a", a, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, parser_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;

    // Basic back-to-back frame, ALU acknowledging in the same cycle.
    frame(8'hA9, 32'h00000005, 32'h00000003, 0, 0);
    chk_frame("basic", 32'h00000005, 32'h00000003, 1'b1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("basic_pd_count", pd_count, 32'd1);

    // Byte order with gaps; the first A byte lands exactly on the idle threshold.
    frame(8'hAA, 32'hDEADBEEF, 32'h01234567, 20, T - 1);
    chk_frame("order", 32'hDEADBEEF, 32'h01234567, 1'b0, 1'b1);

    // Bad header, then a good frame.
    @(posedge clk); #1;
    send(8'h55, 0);
    in_valid = 1'b0;
    chk("bad_err", {31'd0, frame_err}, 32'd1);
    chk("bad_a_hold", a, 32'hDEADBEEF);
    chk("bad_b_hold", b, 32'h01234567);
    frame(8'hA8, 32'h11223344, 32'h55667788, 3, 0);
    chk_frame("after_bad", 32'h11223344, 32'h55667788, 1'b0, 1'b0);

    // Backpressure: ALU holds off completion for 20 cycles.
    @(posedge clk); #1;
    alu_tie = 1'b0;
    frame(8'hAB, 32'h00000001, 32'hFFFFFFFF, 0, 0);
    chk_frame("bp", 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
    in_data = 8'hA9; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    end
    alu_drv = 1'b1;
    @(posedge clk); #1;
    alu_drv = 1'b0;
    alu_tie = 1'b1;
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    frame(8'hA9, 32'hCAFEF00D, 32'h0BADBEEF, 0, 0);
    chk_frame("bp_next", 32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 1'b0);

    // Idle timeout inside operand A.
    @(posedge clk); #1;
    send(8'hA9, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    in_valid = 1'b0;
    repeat (T - 1) begin @(posedge clk); #1; end
    chk("to_early", {31'd0, frame_err}, 32'd0);
    @(posedge clk); #1;
    chk("to_err", {31'd0, frame_err}, 32'd1);
    chk("to_a_hold", a, 32'hCAFEF00D);
    chk("to_b_hold", b, 32'h0BADBEEF);
    frame(8'hAA, 32'h89ABCDEF, 32'h76543210, 0, 0);
    chk_frame("after_to", 32'h89ABCDEF, 32'h76543210, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    @(posedge clk); #1;
    send(8'hAB, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    in_valid = 1'b0;
    #2 n_rst = 1'b1;
    #1;
    chk("mrst_a", a, 32'd0);
    chk("mrst_b", b, 32'd0);
    chk("mrst_op", {31'd0, operator}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    frame(8'hA9, 32'h00000007, 32'h00000009, 0, 0);
    chk_frame("post_rst", 32'h00000007, 32'h00000009, 1'b1, 1'b0);

    repeat (3) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
